// File: rtl/mips_run_monitor.sv
// Run controller and trace monitor for the single-cycle MIPS core.
// Sequences core reset, records a circular PC/ALU trace and a rolling signature, and ends the run on halt or timeout.
module mips_run_monitor #(
  parameter int PC_W            = 16,
  parameter int DATA_W          = 16,
  parameter int DEPTH           = 16,
  parameter int CORE_RST_CYCLES = 5,
  parameter int HALT_CYCLES     = 4,
  parameter int TIMEOUT         = 1024,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1,
  localparam int CYC_W = $clog2(TIMEOUT) + 1,
  localparam int SIG_W = PC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              core_rst_n,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [PC_W-1:0]   rd_pc,
  output logic [DATA_W-1:0] rd_alu,
  output logic [CNT_W-1:0]  trace_count,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [SIG_W-1:0]  signature,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [1:0]        fsm_state
);

  localparam int STALL_W = $clog2(HALT_CYCLES + 1);
  localparam int RCNT_W  = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RESET_CORE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [RCNT_W-1:0]   rst_cnt;
  logic [IDX_W-1:0]    wr_ptr;
  logic [STALL_W-1:0]  stall_cnt, stall_next;
  logic [PC_W-1:0]     prev_pc;
  logic [CYC_W-1:0]    cyc_next;
  logic [SIG_W-1:0]    mem [DEPTH];
  logic                start_ok, halt_hit, to_hit, same_pc;
  logic [IDX_W-1:0]    rd_addr;
  logic                rd_valid;

  // Repeated-PC detection only starts once a previous sample exists in this run.
  assign same_pc    = (cycle_count != '0) && (pc_in == prev_pc);
  assign stall_next = same_pc ? stall_cnt + 1'b1 : '0;
  assign cyc_next   = cycle_count + 1'b1;
  assign halt_hit   = (state == RUN) && (stall_next == STALL_W'(HALT_CYCLES));
  assign to_hit     = (state == RUN) && (cyc_next == CYC_W'(TIMEOUT));
  assign start_ok   = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start_ok) state_next = RESET_CORE;
      RESET_CORE: if (rst_cnt == RCNT_W'(CORE_RST_CYCLES - 1)) state_next = RUN;
      RUN:        if (halt_hit || to_hit) state_next = DONE;
      DONE:       if (start_ok) state_next = RESET_CORE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt     <= '0;
      wr_ptr      <= '0;
      trace_count <= '0;
      cycle_count <= '0;
      signature   <= '0;
      stall_cnt   <= '0;
      prev_pc     <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (start_ok) begin
      rst_cnt     <= '0;
      wr_ptr      <= '0;
      trace_count <= '0;
      cycle_count <= '0;
      signature   <= '0;
      stall_cnt   <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
    end else if (state == RESET_CORE) begin
      rst_cnt <= rst_cnt + 1'b1;
    end else if (state == RUN) begin
      wr_ptr      <= wr_ptr + 1'b1;
      if (trace_count != CNT_W'(DEPTH)) trace_count <= trace_count + 1'b1;
      cycle_count <= cyc_next;
      signature   <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ {pc_in, alu_in};
      prev_pc     <= pc_in;
      stall_cnt   <= stall_next;
      halted      <= halt_hit;
      // A halt on the timeout sample takes precedence.
      timeout     <= to_hit && !halt_hit;
    end
  end

  // Trace storage carries no reset; trace_count masks stale entries.
  always_ff @(posedge clk) begin
    if (state == RUN) mem[wr_ptr] <= {pc_in, alu_in};
  end

  assign rd_addr  = wr_ptr - trace_count[IDX_W-1:0] + rd_idx;
  assign rd_valid = {1'b0, rd_idx} < trace_count;
  assign rd_pc    = rd_valid ? mem[rd_addr][SIG_W-1:DATA_W] : '0;
  assign rd_alu   = rd_valid ? mem[rd_addr][DATA_W-1:0] : '0;

  assign core_rst_n = (state == RUN);
  assign busy       = (state == RESET_CORE) || (state == RUN);
  assign done       = (state == DONE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor with a small trace/signature model (DEPTH=16, TIMEOUT=32).
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        core_rst_n;
  logic [15:0] pc_in = '0;
  logic [15:0] alu_in = '0;
  logic [3:0]  rd_idx = '0;
  logic [15:0] rd_pc, rd_alu;
  logic [4:0]  trace_count;
  logic [5:0]  cycle_count;
  logic [31:0] signature;
  logic        busy, done, halted, timeout;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_sig;
  logic [31:0] exp_q[$];
  int          exp_cyc, stall;
  logic [15:0] prev;
  logic        exp_halt, exp_to;

  mips_run_monitor #(
    .PC_W(16), .DATA_W(16), .DEPTH(16), .CORE_RST_CYCLES(5), .HALT_CYCLES(4), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .core_rst_n(core_rst_n),
    .pc_in(pc_in), .alu_in(alu_in), .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_alu(rd_alu),
    .trace_count(trace_count), .cycle_count(cycle_count), .signature(signature),
    .busy(busy), .done(done), .halted(halted), .timeout(timeout), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_sig = '0;
    exp_q.delete();
    exp_cyc = 0;
    stall = 0;
    prev = '0;
    exp_halt = 1'b0;
    exp_to = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (core_rst_n !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (core_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL wait_run: core_rst_n=%b after %0d cycles, want 1", core_rst_n, n);
    end
  endtask

  // One RUN sample: drive inputs, advance the model, clock it in.
  task automatic feed(input logic [15:0] pc, input logic [15:0] alu);
    pc_in = pc;
    alu_in = alu;
    exp_cyc++;
    if (exp_cyc > 1 && pc == prev) stall++;
    else stall = 0;
    prev = pc;
    exp_sig = {exp_sig[30:0], exp_sig[31]} ^ {pc, alu};
    exp_q.push_back({pc, alu});
    if (exp_q.size() > 16) void'(exp_q.pop_front());
    exp_halt = (stall == 4);
    exp_to = (exp_cyc == 32) && !exp_halt;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL rst_core_rst_n: got %b want 0", core_rst_n); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    checks++; if (trace_count !== 5'd0 || cycle_count !== 6'd0) begin failures++; $display("FAIL rst_counts: got %0d/%0d want 0/0", trace_count, cycle_count); end
    checks++; if (signature !== 32'd0 || halted !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL rst_sig_flags: got %h %b %b want 0", signature, halted, timeout); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_pc !== 16'd0 || rd_alu !== 16'd0) begin failures++; $display("FAIL rst_read: got %h/%h want 0/0", rd_pc, rd_alu); end
    do_start();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (core_rst_n !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL core_reset_window[%0d]: core_rst_n=%b busy=%b want 0 1", i, core_rst_n, busy);
      end
      tick();
    end
    checks++; if (core_rst_n !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL core_release: core_rst_n=%b busy=%b want 1 1", core_rst_n, busy); end
  endtask

  task automatic test_halt();
    logic [15:0] pcs [8] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd12, 16'd12, 16'd12, 16'd12};
    do_reset();
    do_start();
    wait_run();
    for (int i = 0; i < 7; i++) feed(pcs[i], 16'h3000 + 16'(i * 7));
    checks++; if (done !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL halt_early: done=%b halted=%b want 0 0", done, halted); end
    feed(pcs[7], 16'h3031);
    checks++; if (done !== 1'b1 || halted !== exp_halt || timeout !== 1'b0) begin failures++; $display("FAIL halt_flags: done=%b halted=%b timeout=%b want 1 1 0", done, halted, timeout); end
    checks++; if (trace_count !== 5'd8 || cycle_count !== 6'd8) begin failures++; $display("FAIL halt_counts: got %0d/%0d want 8/8", trace_count, cycle_count); end
    checks++; if (signature !== exp_sig) begin failures++; $display("FAIL halt_sig: got %h want %h", signature, exp_sig); end
    checks++; if (core_rst_n !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL halt_core_frozen: core_rst_n=%b busy=%b want 0 0", core_rst_n, busy); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_pc !== 16'd0 || rd_alu !== exp_q[0][15:0]) begin failures++; $display("FAIL halt_rd0: got %h/%h want 0000/%h", rd_pc, rd_alu, exp_q[0][15:0]); end
    rd_idx = 4'd7; #1;
    checks++; if ({rd_pc, rd_alu} !== exp_q[7]) begin failures++; $display("FAIL halt_rd7: got %h%h want %h", rd_pc, rd_alu, exp_q[7]); end
    rd_idx = 4'd8; #1;
    checks++; if (rd_pc !== 16'd0 || rd_alu !== 16'd0) begin failures++; $display("FAIL halt_rd_masked: got %h/%h want 0/0", rd_pc, rd_alu); end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    wait_run();
    for (int i = 0; i < 31; i++) feed(16'(i * 4), 16'hA000 ^ 16'(i));
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL timeout_early: done=%b want 0", done); end
    feed(16'(31 * 4), 16'hA000 ^ 16'd31);
    checks++; if (done !== 1'b1 || timeout !== exp_to || halted !== 1'b0) begin failures++; $display("FAIL timeout_flags: done=%b timeout=%b halted=%b want 1 1 0", done, timeout, halted); end
    checks++; if (cycle_count !== 6'd32 || trace_count !== 5'd16) begin failures++; $display("FAIL timeout_counts: got %0d/%0d want 32/16", cycle_count, trace_count); end
    checks++; if (signature !== exp_sig) begin failures++; $display("FAIL timeout_sig: got %h want %h", signature, exp_sig); end
    rd_idx = 4'd0; #1;
    checks++; if (rd_pc !== 16'd64 || {rd_pc, rd_alu} !== exp_q[0]) begin failures++; $display("FAIL timeout_rd_wrap: got %h%h want %h", rd_pc, rd_alu, exp_q[0]); end
    rd_idx = 4'd15; #1;
    checks++; if ({rd_pc, rd_alu} !== exp_q[15]) begin failures++; $display("FAIL timeout_rd15: got %h%h want %h", rd_pc, rd_alu, exp_q[15]); end
  endtask

  task automatic test_halt_at_timeout();
    do_reset();
    do_start();
    wait_run();
    for (int i = 0; i < 28; i++) feed(16'(i * 4), 16'(i));
    for (int i = 0; i < 4; i++) feed(16'(27 * 4), 16'h55AA);
    checks++; if (done !== 1'b1 || halted !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL halt_vs_timeout: done=%b halted=%b timeout=%b want 1 1 0", done, halted, timeout); end
    checks++; if (cycle_count !== 6'd32 || signature !== exp_sig) begin failures++; $display("FAIL halt_vs_timeout_sig: got %0d %h want 32 %h", cycle_count, signature, exp_sig); end
  endtask

  task automatic test_mid_run_reset();
    do_reset();
    do_start();
    wait_run();
    for (int i = 0; i < 10; i++) feed(16'h0200 + 16'(i * 4), 16'hBEEF - 16'(i));
    checks++; if (trace_count !== 5'd10 || signature !== exp_sig) begin failures++; $display("FAIL pre_rst_state: got %0d %h want 10 %h", trace_count, signature, exp_sig); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fsm_state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_rst_idle: state=%0d busy=%b done=%b want 0 0 0", fsm_state, busy, done); end
    checks++; if (trace_count !== 5'd0 || signature !== 32'd0 || cycle_count !== 6'd0) begin failures++; $display("FAIL mid_rst_clear: got %0d %h %0d want 0 0 0", trace_count, signature, cycle_count); end
    checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL mid_rst_core: got %b want 0", core_rst_n); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pcs [7] = '{16'h100, 16'h104, 16'h108, 16'h108, 16'h108, 16'h108, 16'h108};
    logic [31:0] sig1;
    do_reset();
    do_start();
    wait_run();
    for (int i = 0; i < 7; i++) begin
      start = (i == 2);
      feed(pcs[i], 16'h0F00 + 16'(i * 3));
      start = 1'b0;
      if (i == 2) begin
        checks++; if (busy !== 1'b1 || core_rst_n !== 1'b1 || cycle_count !== 6'd3) begin failures++; $display("FAIL start_in_run: busy=%b core_rst_n=%b cyc=%0d want 1 1 3", busy, core_rst_n, cycle_count); end
      end
    end
    checks++; if (done !== 1'b1 || halted !== 1'b1 || signature !== exp_sig) begin failures++; $display("FAIL run1_end: done=%b halted=%b sig=%h want 1 1 %h", done, halted, signature, exp_sig); end
    sig1 = exp_sig;
    tick();
    tick();
    checks++; if (done !== 1'b1 || signature !== sig1 || trace_count !== 5'd7) begin failures++; $display("FAIL done_hold: done=%b sig=%h cnt=%0d want 1 %h 7", done, signature, trace_count, sig1); end
    do_start();
    checks++; if (trace_count !== 5'd0 || cycle_count !== 6'd0 || signature !== 32'd0 || halted !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL restart_clear: cnt=%0d cyc=%0d sig=%h halted=%b busy=%b want 0 0 0 0 1", trace_count, cycle_count, signature, halted, busy); end
    model_clear();
    wait_run();
    for (int i = 0; i < 7; i++) feed(pcs[i], 16'h0F00 + 16'(i * 3));
    checks++; if (done !== 1'b1 || signature !== sig1) begin failures++; $display("FAIL run2_sig: done=%b sig=%h want 1 %h", done, signature, sig1); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_halt();
    test_timeout();
    test_halt_at_timeout();
    test_mid_run_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
